// File: rtl/barrett_reduce.sv
// rtl/barrett_reduce.sv - three-stage Barrett reduction of a 16-bit product modulo an 8-bit Q
//
// Ports:
//   clock, reset            single clock, asynchronous active-high reset
//   in_data/in_valid/in_ready     16-bit product stream in
//   out_data/out_valid/out_ready  8-bit residue stream out
//   busy                    any pipeline stage holds a valid item
//   out_err (BARRETT_RANGE_CHECK_EN only)  item was larger than (Q-1)^2
//
// Optional feature macro: BARRETT_RANGE_CHECK_EN

module barrett_reduce #(
    parameter int Q  = 251,
    parameter int MU = 261
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef BARRETT_RANGE_CHECK_EN
    output logic        out_err,
`endif
    output logic        busy
);

    localparam logic [7:0] Q_C  = 8'(Q);
    localparam logic [8:0] MU_C = 9'(MU);

    logic        v1, v2, v3;
    logic [24:0] t1;
    logic [9:0]  c1;
    logic [9:0]  r2;
    logic [7:0]  d3;
    logic        advance;

    // Single stall signal for the whole pipe: it moves only when the last
    // stage is empty or being drained this cycle.
    assign advance  = ~v3 | out_ready;
    assign in_ready = advance;

    // Stage 1: estimate product. Only the low 10 bits of the input are kept,
    // since the remainder is known to fit in 10 bits and the subtraction is
    // therefore exact modulo 2^10.
    logic [24:0] t_next;
    assign t_next = {9'b0, in_data} * {16'b0, MU_C};

    // Stage 2: quotient estimate and raw remainder (always below 3Q).
    logic [8:0] qhat;
    logic [9:0] qq;
    logic [9:0] r_next;
    assign qhat   = t1[24:16];
    assign qq     = {1'b0, qhat} * {2'b0, Q_C};
    assign r_next = c1 - qq;

    logic unused_t_lo;
    assign unused_t_lo = &{1'b0, t1[15:0]};

    // Stage 3: up to two conditional subtractions bring r into [0, Q).
    logic [9:0] r_a;
    logic [9:0] r_b;
    assign r_a = (r2  >= {2'b0, Q_C}) ? r2  - {2'b0, Q_C} : r2;
    assign r_b = (r_a >= {2'b0, Q_C}) ? r_a - {2'b0, Q_C} : r_a;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            t1 <= '0;
            c1 <= '0;
            r2 <= '0;
            d3 <= '0;
        end else if (advance) begin
            v1 <= in_valid & in_ready;
            v2 <= v1;
            v3 <= v2;
            t1 <= t_next;
            c1 <= in_data[9:0];
            r2 <= r_next;
            d3 <= r_b[7:0];
        end
    end

`ifdef BARRETT_RANGE_CHECK_EN
    localparam logic [15:0] ERR_LIMIT = 16'((Q - 1) * (Q - 1));
    logic e1, e2, e3;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            e1 <= 1'b0;
            e2 <= 1'b0;
            e3 <= 1'b0;
        end else if (advance) begin
            e1 <= in_data > ERR_LIMIT;
            e2 <= e1;
            e3 <= e2;
        end
    end

    assign out_err = e3;
`endif

    assign out_valid = v3;
    assign out_data  = d3;
    assign busy      = v1 | v2 | v3;

endmodule

// File: tb/tb_barrett_reduce.sv
// tb/tb_barrett_reduce.sv - self-checking bench for barrett_reduce against a modulo reference queue

module tb_barrett_reduce;

    localparam int Q  = 251;
    localparam int MU = 261;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
`ifdef BARRETT_RANGE_CHECK_EN
    logic        out_err;
`endif

    barrett_reduce #(.Q(Q), .MU(MU)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef BARRETT_RANGE_CHECK_EN
        .out_err   (out_err),
`endif
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    logic       err_q[$];
    logic       acc;
    logic       got;
    logic [7:0] got_data;
    logic       got_err;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    endtask

    // One clock cycle: drive inputs after the falling edge, then score the
    // handshakes that will complete on the following rising edge.
    task automatic step(input logic iv, input logic [15:0] id, input logic ordy);
        @(negedge clock);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        got = out_valid && out_ready;
        got_err = 1'b0;
        if (got) begin
            got_data = out_data;
`ifdef BARRETT_RANGE_CHECK_EN
            got_err = out_err;
`endif
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(1), 32'(0));
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
`ifdef BARRETT_RANGE_CHECK_EN
                check("out_err", 32'(out_err), 32'(err_q.pop_front()));
`else
                void'(err_q.pop_front());
`endif
            end
        end
        if (acc) begin
            exp_q.push_back(8'(int'(id) % Q));
            err_q.push_back(int'(id) > (Q - 1) * (Q - 1));
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            step(1'b0, 16'h0, 1'b1);
            k++;
        end
        check(tag, 32'(exp_q.size()), 32'(0));
    endtask

    logic [15:0] din  [6] = '{16'd0, 16'd250, 16'd251, 16'd502, 16'd62500, 16'd65535};
    logic [7:0]  dexp [6] = '{8'd0, 8'd250, 8'd0, 8'd0, 8'd1, 8'd24};
    logic [7:0]  hold_data;
    int          lat;
    int          n_out;
    int          tries;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_busy",      32'(busy),      32'(0));
        check("rst_out_data",  32'(out_data),  32'(0));
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(1));

        // Directed values with latency measurement.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, din[i], 1'b1);
            check("dir_accept", 32'(acc), 32'(1));
            lat = 0;
            do begin
                step(1'b0, 16'h0, 1'b1);
                lat++;
            end while (!got && lat < 10);
            check("dir_latency", 32'(lat), 32'(3));
            check("dir_value", 32'(got_data), 32'(dexp[i]));
`ifdef BARRETT_RANGE_CHECK_EN
            check("dir_err", 32'(got_err), 32'(din[i] > 16'd62500));
`endif
        end

        // Back-to-back random stream at full rate.
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 16'($urandom), 1'b1);
            check("stream_accept", 32'(acc), 32'(1));
            if (i >= 3) check("stream_rate", 32'(got), 32'(1));
        end
        drain("stream_drain");

        // Backpressure with the pipeline full.
        for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 16'($urandom), 1'b0);
            if (k == 0) hold_data = out_data;
            check("bp_in_ready", 32'(in_ready),  32'(0));
            check("bp_accept",   32'(acc),       32'(0));
            check("bp_valid",    32'(out_valid), 32'(1));
            check("bp_data",     32'(out_data),  32'(hold_data));
        end
        drain("bp_drain");

        // Reset with three items in flight.
        for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 1'b1);
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_busy",      32'(busy),      32'(0));
        exp_q.delete();
        err_q.delete();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        n_out = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 16'h0, 1'b1);
            if (got) n_out++;
        end
        check("midrst_stale", 32'(n_out), 32'(0));

        // Exhaustive sweep with occasional downstream stalls.
        for (int i = 0; i < 65536; i++) begin
            tries = 0;
            do begin
                step(1'b1, 16'(i), 1'($urandom_range(15) != 0));
                tries++;
            end while (!acc && tries < 50);
            if (!acc) check("sweep_stall", 32'(0), 32'(1));
        end
        drain("sweep_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
